req_encoder_rr: RTL

REQ_ENCODER_RR -- requirements
Module: req_encoder_rr

---
 rtl/req_encoder_rr_if.sv | 26 ++
 rtl/req_encoder_rr.sv | 85 ++++++++
 2 files changed

// File: rtl/req_encoder_rr_if.sv
// Request-encoder bus: request side in, encoded result with valid/ready out.
interface req_encoder_rr_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned W = $clog2(N);

  logic         en;
  logic         mode;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] idx;
  logic         multi;

  // Producer/consumer side (drives requests, accepts results)
  modport master (
    output en, mode, req, out_ready,
    input  out_valid, idx, multi
  );

  // Encoder side
  modport slave (
    input  en, mode, req, out_ready,
    output out_valid, idx, multi
  );
endinterface

// File: rtl/req_encoder_rr.sv
// Priority encoder with fixed or round-robin arbitration and a one-deep
// valid/ready result register. The round-robin pointer advances only on
// round-robin captures.
module req_encoder_rr #(
  parameter int unsigned N = 8
) (
  input logic             clk,
  input logic             rst_n,
  req_encoder_rr_if.slave bus
);
  localparam int unsigned W = $clog2(N);

  logic [W-1:0] ptr;
  logic [W-1:0] idx_q;
  logic         multi_q;
  logic         valid_q;

  logic [W-1:0] fixed_idx_c;
  logic         fixed_hit_c;
  logic [W-1:0] rr_idx_c;
  logic         rr_hit_c;
  int unsigned  pos_c;
  logic [W-1:0] winner_c;
  logic [W-1:0] next_ptr_c;
  logic         multi_c;
  logic         slot_free_c;
  logic         capture_c;

  // Lowest set index, scanning upward from bit 0
  always_comb begin
    fixed_idx_c = '0;
    fixed_hit_c = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!fixed_hit_c && bus.req[i]) begin
        fixed_idx_c = W'(i);
        fixed_hit_c = 1'b1;
      end
    end
  end

  // First set index scanning upward from ptr, wrapping N-1 -> 0
  always_comb begin
    rr_idx_c = '0;
    rr_hit_c = 1'b0;
    pos_c    = 0;
    for (int unsigned i = 0; i < N; i++) begin
      pos_c = 32'(ptr) + i;
      if (pos_c >= N) pos_c = pos_c - N;
      if (!rr_hit_c && bus.req[pos_c[W-1:0]]) begin
        rr_idx_c = pos_c[W-1:0];
        rr_hit_c = 1'b1;
      end
    end
  end

  // Winner selection, pointer successor and capture decision
  always_comb begin
    winner_c    = bus.mode ? rr_idx_c : fixed_idx_c;
    next_ptr_c  = (winner_c == W'(N - 1)) ? '0 : winner_c + W'(1);
    multi_c     = |(bus.req & (bus.req - N'(1)));
    slot_free_c = !valid_q || bus.out_ready;
    capture_c   = bus.en && (|bus.req) && slot_free_c;
  end

  // Result register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
      ptr     <= '0;
    end else if (capture_c) begin
      idx_q   <= winner_c;
      multi_q <= multi_c;
      valid_q <= 1'b1;
      if (bus.mode) ptr <= next_ptr_c;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.idx       = idx_q;
  assign bus.multi     = multi_q;
  assign bus.out_valid = valid_q;
endmodule
